// File: rtl/pb_ctrl_pkg.sv
// Shared types and default timing values for the push-button gesture controller.
// The state codes are also visible on state_o, so their encodings are fixed here.
package pb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HELD   = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_PRESS2 = 3'd4
  } state_e;

  localparam int LONG_TICKS_DEF   = 100;
  localparam int DBL_GAP_DEF      = 30;
  localparam int REPEAT_TICKS_DEF = 20;
  localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/pb_tick_cnt.sv
// Tick counter shared by all gesture timing windows.
// When clr and inc are both high, clr takes priority.
module pb_tick_cnt
  import pb_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pb_gesture_ctrl.sv
// Press-gesture classifier for one debounced button: short, long, double and auto-repeat pulses.
// Every output is a flop, so a pulse appears on the same edge as the state change that causes it.
module pb_gesture_ctrl
  import pb_ctrl_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DBL_GAP      = DBL_GAP_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pb_deb,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_GAP - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  state_e           state_d, state_q;
  logic             short_d, short_q;
  logic             long_d, long_q;
  logic             dbl_d, dbl_q;
  logic             rep_d, rep_q;
  logic             busy_d, busy_q;
  logic             cnt_clr, cnt_inc;
  logic [CNT_W-1:0] cnt;

  pb_tick_cnt #(.CNT_W(CNT_W)) u_tick_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  // NOTE: every signal is assigned a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_d   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          if (pb_deb) state_d = ST_PRESS1;
        end
        // A release on the long-timeout edge is still a release.
        ST_PRESS1: begin
          if (!pb_deb) begin
            state_d = ST_WAIT2;
            cnt_clr = 1'b1;
          end else if (cnt == LONG_LAST) begin
            state_d = ST_HELD;
            cnt_clr = 1'b1;
            long_d  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_HELD: begin
          if (!pb_deb) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else if (cnt == REP_LAST) begin
            cnt_clr = 1'b1;
            rep_d   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        // A second press on the gap-timeout edge still counts as a double press.
        ST_WAIT2: begin
          if (pb_deb) begin
            state_d = ST_PRESS2;
            cnt_clr = 1'b1;
            dbl_d   = 1'b1;
          end else if (cnt == DBL_LAST) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            short_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_PRESS2: begin
          cnt_clr = 1'b1;
          if (!pb_deb) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = dbl_q;
  assign repeat_pulse = rep_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pb_gesture_ctrl.sv
// Directed bench for pb_gesture_ctrl: default-timing instance plus a minimum-window instance (all ticks = 2).
// Expected cycle offsets are derived from the transition rules; pulse counts are accumulated every cycle.
module tb_pb_gesture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pb_deb;

  logic       short_press, long_press, double_press, repeat_pulse, busy;
  logic [2:0] state_o;
  logic       m_short, m_long, m_dbl, m_rep, m_busy;
  logic [2:0] m_state;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_short, n_long, n_dbl, n_rep, n_multi;
  int short_cyc, long_cyc, dbl_cyc, rep_first, rep_last;
  int mark;

  always #5 clk = ~clk;

  pb_gesture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pb_deb       (pb_deb),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy),
    .state_o      (state_o)
  );

  pb_gesture_ctrl #(
    .LONG_TICKS   (2),
    .DBL_GAP      (2),
    .REPEAT_TICKS (2),
    .CNT_W        (8)
  ) dut_min (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pb_deb       (pb_deb),
    .short_press  (m_short),
    .long_press   (m_long),
    .double_press (m_dbl),
    .repeat_pulse (m_rep),
    .busy         (m_busy),
    .state_o      (m_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0;
    short_cyc = -1; long_cyc = -1; dbl_cyc = -1; rep_first = -1; rep_last = -1;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it and pulses are logged.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if ((32'(short_press) + 32'(long_press) + 32'(double_press) + 32'(repeat_pulse)) > 1) n_multi++;
    if (short_press)  begin n_short++; short_cyc = cyc; end
    if (long_press)   begin n_long++;  long_cyc  = cyc; end
    if (double_press) begin n_dbl++;   dbl_cyc   = cyc; end
    if (repeat_pulse) begin
      if (n_rep == 0) rep_first = cyc;
      n_rep++;
      rep_last = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Minimum-window instance: drive pb, take one edge, compare {short,long,dbl,rep,busy,state}.
  task automatic tv(input string tag, input logic pbv, input logic [7:0] exp);
    pb_deb = pbv;
    tick();
    check(tag, {m_short, m_long, m_dbl, m_rep, m_busy, m_state}, exp);
  endtask

  initial begin
    n_multi = 0;
    clear_counts();
    rst_n  = 1'b0;
    en     = 1'b0;
    pb_deb = 1'b0;
    #12;
    check("rst_state", state_o, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {short_press, long_press, double_press, repeat_pulse}, 4'b0000);
    check("rst_min_state", m_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    ticks(3);

    // 1: single short press
    clear_counts();
    pb_deb = 1'b1; ticks(10);
    pb_deb = 1'b0; tick();
    mark = cyc;
    check("t1_wait2", state_o, 3'd3);
    ticks(39);
    check("t1_short_cnt", n_short, 1);
    check("t1_short_cyc", short_cyc, mark + 30);
    check("t1_other", n_long + n_dbl + n_rep, 0);
    check("t1_busy", busy, 1'b0);

    // 2: double press
    clear_counts();
    pb_deb = 1'b1; ticks(10);
    pb_deb = 1'b0; ticks(15);
    pb_deb = 1'b1; tick();
    mark = cyc;
    check("t2_press2", state_o, 3'd4);
    ticks(9);
    pb_deb = 1'b0; ticks(40);
    check("t2_dbl_cnt", n_dbl, 1);
    check("t2_dbl_cyc", dbl_cyc, mark);
    check("t2_no_short", n_short + n_long + n_rep, 0);
    check("t2_busy", busy, 1'b0);

    // 3: long press with auto-repeat
    clear_counts();
    pb_deb = 1'b1; tick();
    mark = cyc;
    ticks(149);
    check("t3_long_cnt", n_long, 1);
    check("t3_long_cyc", long_cyc, mark + 100);
    check("t3_rep_cnt", n_rep, 2);
    check("t3_rep_first", rep_first, mark + 120);
    check("t3_rep_last", rep_last, mark + 140);
    check("t3_held", state_o, 3'd2);
    pb_deb = 1'b0; ticks(40);
    check("t3_no_short", n_short + n_dbl, 0);
    check("t3_busy", busy, 1'b0);

    // 4: second press lands on the gap-timeout edge
    clear_counts();
    pb_deb = 1'b1; ticks(10);
    pb_deb = 1'b0; tick();
    mark = cyc;
    ticks(29);
    pb_deb = 1'b1; tick();
    check("t4_dbl_cyc", dbl_cyc, mark + 30);
    check("t4_state", state_o, 3'd4);
    ticks(4);
    pb_deb = 1'b0; ticks(5);
    check("t4_dbl_cnt", n_dbl, 1);
    check("t4_no_short", n_short, 0);
    check("t4_busy", busy, 1'b0);

    // 4b: release lands on the long-timeout edge
    clear_counts();
    pb_deb = 1'b1; tick();
    mark = cyc;
    ticks(99);
    pb_deb = 1'b0; tick();
    check("t4b_wait2", state_o, 3'd3);
    check("t4b_no_long", n_long, 0);
    ticks(39);
    check("t4b_short_cnt", n_short, 1);
    check("t4b_short_cyc", short_cyc, mark + 130);

    // 5: en dropped in HELD, then reset mid-WAIT2
    clear_counts();
    pb_deb = 1'b1; ticks(110);
    check("t5_held", state_o, 3'd2);
    clear_counts();
    en = 1'b0; tick();
    check("t5_en_idle", state_o, 3'd0);
    check("t5_en_busy", busy, 1'b0);
    ticks(3);
    check("t5_en_stay", state_o, 3'd0);
    en = 1'b1; tick();
    check("t5_fresh_press", state_o, 3'd1);
    pb_deb = 1'b0; tick();
    check("t5_wait2", state_o, 3'd3);
    ticks(5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_state", state_o, 3'd0);
    check("t5_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(40);
    check("t5_no_pulses", n_short + n_long + n_dbl + n_rep, 0);
    check("t5_busy", busy, 1'b0);
    check("one_pulse_per_cycle", n_multi, 0);

    // 6: minimum windows (LONG=DBL=REPEAT=2)
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tv("m_press",      1'b1, 8'b0000_1_001);
    tv("m_press_cnt",  1'b1, 8'b0000_1_001);
    tv("m_long",       1'b1, 8'b0100_1_010);
    tv("m_held_cnt",   1'b1, 8'b0000_1_010);
    tv("m_repeat",     1'b1, 8'b0001_1_010);
    tv("m_held_rel",   1'b0, 8'b0000_0_000);
    tv("m_p1",         1'b1, 8'b0000_1_001);
    tv("m_w2",         1'b0, 8'b0000_1_011);
    tv("m_w2_cnt",     1'b0, 8'b0000_1_011);
    tv("m_short",      1'b0, 8'b1000_0_000);
    tv("m_p1b",        1'b1, 8'b0000_1_001);
    tv("m_w2b",        1'b0, 8'b0000_1_011);
    tv("m_w2b_cnt",    1'b0, 8'b0000_1_011);
    tv("m_dbl_edge",   1'b1, 8'b0010_1_100);
    tv("m_p2_rel",     1'b0, 8'b0000_0_000);
    tv("m_p1c",        1'b1, 8'b0000_1_001);
    tv("m_p1c_cnt",    1'b1, 8'b0000_1_001);
    tv("m_rel_on_long",1'b0, 8'b0000_1_011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
